led_sequencer: RTL

Command-driven sequencer for the 8-LED display. It owns a programmable tick divider and a mode state machine, and advances a registered LED pattern one position per tick. Supported modes are rotate-right, rotate-left, bounce, stopped and single-step. It sits between the board-level control logic, which issues commands over a valid/ready port, and the LED pins.

---
 rtl/led_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: command-driven 8-LED pattern sequencer.
// A programmable down-counter produces a tick; on each tick the LED pattern
// advances according to the current mode (rotate, bounce, stop, single step).
module led_sequencer #(
  parameter int         DIV_WIDTH   = 23,
  parameter logic [7:0] RESET_SPEED = 8'h1F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] leds,
  output logic       tick,
  output logic       wrap
);

  localparam int LOW_W = DIV_WIDTH - 8;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SET_SPEED = 3'd1;
  localparam logic [2:0] OP_RUN_R     = 3'd2;
  localparam logic [2:0] OP_RUN_L     = 3'd3;
  localparam logic [2:0] OP_BOUNCE    = 3'd4;
  localparam logic [2:0] OP_STOP      = 3'd5;
  localparam logic [2:0] OP_LOAD      = 3'd6;
  localparam logic [2:0] OP_STEP      = 3'd7;

  // state        | meaning
  // ST_STOPPED   | leds hold
  // ST_RUN_R     | rotate toward LSB on each tick
  // ST_RUN_L     | rotate toward MSB on each tick
  // ST_BOUNCE_R  | moving toward LSB, reverse when bit 0 is lit
  // ST_BOUNCE_L  | moving toward MSB, reverse when bit 7 is lit
  // ST_STEP_WAIT | one right shift pending on next tick, commands blocked
  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_RUN_R,
    ST_RUN_L,
    ST_BOUNCE_R,
    ST_BOUNCE_L,
    ST_STEP_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           speed_q, speed_d;
  logic [7:0]           leds_q, leds_d;
  logic                 wrap_q, wrap_d;
  logic                 accept, reload_cmd, expired, shift_en;

  function automatic logic [DIV_WIDTH-1:0] reload_of(input logic [7:0] spd);
    return {spd, {LOW_W{1'b1}}};
  endfunction

  function automatic logic [7:0] rot_r(input logic [7:0] p);
    return {p[0], p[7:1]};
  endfunction

  function automatic logic [7:0] rot_l(input logic [7:0] p);
    return {p[6:0], p[7]};
  endfunction

  assign cmd_ready  = (state_q != ST_STEP_WAIT);
  assign accept     = cmd_valid && cmd_ready;
  // every opcode except NOP and LOAD restarts the divider
  assign reload_cmd = accept && (cmd_op != OP_NOP) && (cmd_op != OP_LOAD);
  assign expired    = (cnt_q == '0);
  // an accepted command always takes priority over the tick's shift
  assign shift_en   = expired && !accept;
  assign tick       = expired && !reload_cmd;
  assign leds       = leds_q;
  assign wrap       = wrap_q;

  // State, divider, speed, pattern and wrap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOPPED;
      cnt_q   <= reload_of(RESET_SPEED);
      speed_q <= RESET_SPEED;
      leds_q  <= 8'b1000_0000;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
      leds_q  <= leds_d;
      wrap_q  <= wrap_d;
    end
  end

  // Command decode, divider next value and per-tick pattern update.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    leds_d  = leds_q;
    wrap_d  = 1'b0;
    cnt_d   = expired ? reload_of(speed_q) : cnt_q - DIV_WIDTH'(1);

    if (accept) begin
      case (cmd_op)
        OP_SET_SPEED: speed_d = cmd_data;
        OP_RUN_R:     state_d = ST_RUN_R;
        OP_RUN_L:     state_d = ST_RUN_L;
        OP_BOUNCE:    state_d = ST_BOUNCE_R;
        OP_STOP:      state_d = ST_STOPPED;
        OP_LOAD:      leds_d  = cmd_data;
        OP_STEP:      state_d = (state_q == ST_STOPPED) ? ST_STEP_WAIT : ST_STOPPED;
        default:      ;
      endcase
      if (reload_cmd) cnt_d = reload_of(speed_d);
    end else if (shift_en) begin
      case (state_q)
        ST_RUN_R: begin
          leds_d = rot_r(leds_q);
          wrap_d = leds_q[0];
        end
        ST_RUN_L: begin
          leds_d = rot_l(leds_q);
          wrap_d = leds_q[7];
        end
        ST_BOUNCE_R: begin
          if (leds_q[0]) begin
            state_d = ST_BOUNCE_L;
            leds_d  = rot_l(leds_q);
            wrap_d  = 1'b1;
          end else begin
            leds_d = rot_r(leds_q);
          end
        end
        ST_BOUNCE_L: begin
          if (leds_q[7]) begin
            state_d = ST_BOUNCE_R;
            leds_d  = rot_r(leds_q);
            wrap_d  = 1'b1;
          end else begin
            leds_d = rot_l(leds_q);
          end
        end
        ST_STEP_WAIT: begin
          leds_d  = rot_r(leds_q);
          wrap_d  = leds_q[0];
          state_d = ST_STOPPED;
        end
        default: ;
      endcase
    end
  end

endmodule
